// File: rtl/microc_pc_stack.sv
// microc program counter with encoded PC ops, z-conditional jumps and CALL/RET return stack.
// Optional interrupt entry and RETI are enabled by defining MICROC_PC_IRQ_EN.
module microc_pc_stack #(
   parameter int AW      = 10,
   parameter int DEPTH   = 8,
   parameter int IRQ_VEC = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               pc_op,
   input  logic [AW-1:0]            target,
   input  logic                     z,
   output logic [AW-1:0]            pc,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     stack_full,
   output logic                     stack_empty,
`ifdef MICROC_PC_IRQ_EN
   input  logic                     irq,
   output logic                     irq_ack,
`endif
   output logic                     err
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;
   localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

   typedef enum logic [2:0] {
      OP_INC  = 3'b000,
      OP_JMP  = 3'b001,
      OP_JZ   = 3'b010,
      OP_JNZ  = 3'b011,
      OP_CALL = 3'b100,
      OP_RET  = 3'b101,
      OP_HOLD = 3'b110,
      OP_RETI = 3'b111
   } op_e;

   op_e            op;
   logic [AW-1:0]  stk [DEPTH];
   logic [AW-1:0]  inc;
   logic [AW-1:0]  flow_pc;
   logic [AW-1:0]  pc_n;
   logic [AW-1:0]  top;
   logic [SPW-1:0] sp_n;
   logic [SPW-1:0] sp_m1;
   logic           err_n;
   logic           push;
   logic           is_call;
   logic           is_ret;
`ifdef MICROC_PC_IRQ_EN
   logic           in_isr;
   logic           isr_n;
   logic           take_irq;
`endif

   assign op          = op_e'(pc_op);
   assign inc         = pc + 1'b1;
   assign sp_m1       = sp - 1'b1;
   assign top         = stk[sp_m1[IW-1:0]];
   assign stack_full  = (sp == FULL);
   assign stack_empty = (sp == '0);
   assign is_call     = (op == OP_CALL);
`ifdef MICROC_PC_IRQ_EN
   assign is_ret      = (op == OP_RET) || (op == OP_RETI);
`else
   assign is_ret      = (op == OP_RET);
`endif

   // CALL falls to the default arm, so flow_pc is also its return address
   always_comb begin
      flow_pc = inc;
      unique case (op)
         OP_JMP:  flow_pc = target;
         OP_JZ:   flow_pc = z ? target : inc;
         OP_JNZ:  flow_pc = z ? inc : target;
         OP_HOLD: flow_pc = pc;
         default: flow_pc = inc;
      endcase
   end

   always_comb begin
      pc_n  = flow_pc;
      sp_n  = sp;
      err_n = err;
      push  = 1'b0;
`ifdef MICROC_PC_IRQ_EN
      isr_n    = in_isr;
      take_irq = 1'b0;
`endif
      unique case (1'b1)
         is_call: begin
            if (stack_full) begin
               pc_n  = pc;
               err_n = 1'b1;
            end else begin
               push = 1'b1;
               pc_n = target;
               sp_n = sp + 1'b1;
            end
         end
         is_ret: begin
            if (stack_empty) begin
               pc_n  = pc;
               err_n = 1'b1;
            end else begin
               pc_n = top;
               sp_n = sp_m1;
            end
`ifdef MICROC_PC_IRQ_EN
            if (op == OP_RETI) isr_n = 1'b0;
`endif
         end
         default: begin
`ifdef MICROC_PC_IRQ_EN
            if (irq && !in_isr && !stack_full) begin
               take_irq = 1'b1;
               push     = 1'b1;
               isr_n    = 1'b1;
               pc_n     = AW'(IRQ_VEC);
               sp_n     = sp + 1'b1;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc  <= '0;
         sp  <= '0;
         err <= 1'b0;
`ifdef MICROC_PC_IRQ_EN
         in_isr  <= 1'b0;
         irq_ack <= 1'b0;
`endif
      end else begin
         pc  <= pc_n;
         sp  <= sp_n;
         err <= err_n;
`ifdef MICROC_PC_IRQ_EN
         in_isr  <= isr_n;
         irq_ack <= take_irq;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) stk[sp[IW-1:0]] <= flow_pc;
   end

endmodule

// File: tb/tb_microc_pc_stack.sv
// Directed self-checking bench for microc_pc_stack (default build, AW=10, DEPTH=8).
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_microc_pc_stack;

   localparam int AW    = 10;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    pc_op;
   logic [AW-1:0] target;
   logic          z;
   logic [AW-1:0] pc;
   logic [3:0]    sp;
   logic          stack_full;
   logic          stack_empty;
   logic          err;

   int npass = 0;
   int ntot  = 0;

   microc_pc_stack #(.AW(AW), .DEPTH(DEPTH), .IRQ_VEC(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_op       (pc_op),
      .target      (target),
      .z           (z),
      .pc          (pc),
      .sp          (sp),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input logic [2:0] op, input logic [AW-1:0] tgt,
                       input logic zz);
      pc_op  = op;
      target = tgt;
      z      = zz;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_st(input string tag, input int epc, input int esp,
                         input logic eerr);
      chk({tag, ".pc"}, 32'(pc), 32'(epc));
      chk({tag, ".sp"}, 32'(sp), 32'(esp));
      chk({tag, ".err"}, 32'(err), 32'(eerr));
      chk({tag, ".full"}, 32'(stack_full), 32'(esp == DEPTH));
      chk({tag, ".empty"}, 32'(stack_empty), 32'(esp == 0));
   endtask

   initial begin
      reset  = 1'b1;
      pc_op  = 3'b000;
      target = '0;
      z      = 1'b0;
      step(3'b000, 10'h000, 1'b0);
      chk_st("reset", 0, 0, 1'b0);
      reset = 1'b0;

      // sequential flow
      step(3'b000, 10'h000, 1'b0); chk_st("inc1", 1, 0, 1'b0);
      step(3'b000, 10'h000, 1'b0); chk_st("inc2", 2, 0, 1'b0);
      step(3'b000, 10'h000, 1'b0); chk_st("inc3", 3, 0, 1'b0);

      // jumps, hold, 111 behaves as INC
      step(3'b001, 10'h005, 1'b0); chk("jmp", 32'(pc), 32'h005);
      step(3'b010, 10'h009, 1'b0); chk("jz_nt", 32'(pc), 32'h006);
      step(3'b011, 10'h009, 1'b0); chk("jnz_t", 32'(pc), 32'h009);
      step(3'b110, 10'h123, 1'b1); chk("hold", 32'(pc), 32'h009);
      step(3'b111, 10'h123, 1'b0); chk_st("op111", 'h00A, 0, 1'b0);
      step(3'b011, 10'h030, 1'b1); chk("jnz_nt", 32'(pc), 32'h00B);
      step(3'b001, 10'h003, 1'b0); chk("jmp3", 32'(pc), 32'h003);
      step(3'b010, 10'h009, 1'b1); chk("jz_t", 32'(pc), 32'h009);

      // single call/return
      step(3'b100, 10'h020, 1'b0); chk_st("call1", 'h020, 1, 1'b0);
      step(3'b000, 10'h000, 1'b0); chk_st("call1.inc", 'h021, 1, 1'b0);
      step(3'b101, 10'h000, 1'b0); chk_st("ret1", 'h00A, 0, 1'b0);

      // fill stack with distinct return addresses: 0x0B, 0x41..0x47
      for (int i = 0; i < DEPTH; i++) begin
         step(3'b100, 10'(32'h040 + i), 1'b0);
         chk_st($sformatf("fill%0d", i), 'h040 + i, i + 1, 1'b0);
      end
      step(3'b100, 10'h100, 1'b0); chk_st("ovf", 'h047, DEPTH, 1'b1);

      for (int j = 0; j < DEPTH; j++) begin
         step(3'b101, 10'h000, 1'b0);
         chk_st($sformatf("pop%0d", j), (j < DEPTH - 1) ? ('h047 - j) : 'h00B,
                DEPTH - 1 - j, 1'b1);
      end
      step(3'b101, 10'h000, 1'b0); chk_st("unf", 'h00B, 0, 1'b1);
      step(3'b000, 10'h000, 1'b0); chk_st("err_sticky", 'h00C, 0, 1'b1);

      reset = 1'b1;
      step(3'b000, 10'h000, 1'b0); chk_st("reset2", 0, 0, 1'b0);
      reset = 1'b0;

      // reset wins over a CALL
      step(3'b001, 10'h010, 1'b0);
      reset = 1'b1;
      step(3'b100, 10'h077, 1'b0); chk_st("reset_call", 0, 0, 1'b0);
      reset = 1'b0;

      // address wrap
      step(3'b001, 10'h3FF, 1'b0); chk("top", 32'(pc), 32'h3FF);
      step(3'b000, 10'h000, 1'b0); chk("wrap", 32'(pc), 32'h000);
      step(3'b001, 10'h3FF, 1'b0);
      step(3'b100, 10'h055, 1'b0); chk_st("call_wrap", 'h055, 1, 1'b0);
      step(3'b101, 10'h000, 1'b0); chk_st("ret_wrap", 'h000, 0, 1'b0);

      // call to the next address
      step(3'b100, 10'h001, 1'b0); chk_st("call_next", 'h001, 1, 1'b0);
      step(3'b001, 10'h200, 1'b0); chk("jmp_away", 32'(pc), 32'h200);
      step(3'b101, 10'h000, 1'b0); chk_st("ret_next", 'h001, 0, 1'b0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
